// File: rtl/xrog_policy_engine_pipe.sv
// xrog_policy_engine_pipe: request FIFO, double-buffered policy word, and a
// three-state evaluator (IDLE -> EVAL -> RESP). It applies the residency,
// rate-limit, audit and latency rules to each request in that priority order.
// A per-window op counter feeds the rate rule, and saturating counters track
// blocked and flagged decisions.
`timescale 1ns/1ps
module xrog_policy_engine_pipe #(
    parameter int PAYLOAD_W   = 1024,
    parameter int DOMAIN_W    = 32,
    parameter int POLICY_W    = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int RISK_THRESH = 3,
    parameter int LAT_THRESH  = 100,
    parameter int RATE_WINDOW = 256,
    parameter int RATE_MAX    = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [POLICY_W-1:0]  pol_data,
    input  logic                 pol_load,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_op,
    input  logic [DOMAIN_W-1:0]  req_src,
    input  logic [DOMAIN_W-1:0]  req_dst,
    input  logic [PAYLOAD_W-1:0] req_payload,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_allowed,
    output logic [PAYLOAD_W-1:0] rsp_payload,
    output logic [7:0]           rsp_action,
    output logic [31:0]          rsp_code,
    output logic [CNT_W-1:0]     stat_block,
    output logic [CNT_W-1:0]     stat_viol,
    output logic                 busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int HALF  = DOMAIN_W / 2;
    localparam int WIN_W = (RATE_WINDOW > 2) ? $clog2(RATE_WINDOW) : 1;
    localparam int OPC_W = $clog2(RATE_MAX + 1);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    state_t state;

    logic [7:0]           fifo_op      [FIFO_DEPTH];
    logic [DOMAIN_W-1:0]  fifo_src     [FIFO_DEPTH];
    logic [DOMAIN_W-1:0]  fifo_dst     [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0] fifo_payload [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count, count_next;

    logic [POLICY_W-1:0]  pol_pend, pol_act;
    logic                 pol_armed;

    logic [7:0]           cur_op;
    logic [DOMAIN_W-1:0]  cur_src, cur_dst;
    logic [PAYLOAD_W-1:0] cur_payload;

    logic [WIN_W-1:0]     win_cnt;
    logic [OPC_W-1:0]     op_cnt;

    logic                 push, pop, win_wrap, eval_ok;
    logic                 dec_allowed;
    logic [PAYLOAD_W-1:0] dec_payload;
    logic [7:0]           dec_action;
    logic [31:0]          dec_code;

    assign push     = req_valid & req_ready;
    assign pop      = (state == IDLE) && (count != '0) && pol_armed;
    assign win_wrap = (win_cnt == WIN_W'(RATE_WINDOW - 1));
    assign eval_ok  = (state == EVAL) && dec_allowed;
    assign busy     = (state != IDLE) || (count != '0);

    // Occupancy after this edge; req_ready registers its complement.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    // Rule evaluation on the popped request against the active policy.
    always_comb begin
        dec_allowed = 1'b1;
        dec_payload = cur_payload;
        dec_action  = 8'd0;
        dec_code    = 32'd0;
        if (pol_act[56] && (cur_src[DOMAIN_W-1:HALF] != cur_dst[DOMAIN_W-1:HALF])) begin
            dec_allowed = 1'b0;
            dec_action  = 8'd1;
            dec_code    = 32'h4441_5431;
        end else if (op_cnt == OPC_W'(RATE_MAX)) begin
            dec_allowed = 1'b0;
            dec_action  = 8'd3;
            dec_code    = 32'h5241_5431;
        end
        if (dec_allowed && (pol_act[31:24] > 8'(RISK_THRESH)) && (cur_op == 8'd4)) begin
            dec_action             = 8'd2;
            dec_payload[PAYLOAD_W-1] = 1'b1;
        end
        if ((dec_code == 32'd0) && (pol_act[95:64] < 32'(LAT_THRESH)) &&
            (cur_src[HALF-1:0] != cur_dst[HALF-1:0]))
            dec_code = 32'h4C41_5431;
    end

    // Request FIFO storage, pointers and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_op[i]      <= '0;
                fifo_src[i]     <= '0;
                fifo_dst[i]     <= '0;
                fifo_payload[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push) begin
                fifo_op[wr_ptr]      <= req_op;
                fifo_src[wr_ptr]     <= req_src;
                fifo_dst[wr_ptr]     <= req_dst;
                fifo_payload[wr_ptr] <= req_payload;
                wr_ptr               <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            req_ready <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    // Pending/active policy buffers; active only refreshes while IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pol_pend  <= '0;
            pol_act   <= '0;
            pol_armed <= 1'b0;
        end else begin
            if (pol_load) begin
                pol_pend  <= pol_data;
                pol_armed <= 1'b1;
            end
            if ((state == IDLE) && pol_armed)
                pol_act <= pol_pend;
        end
    end

    // Evaluator FSM with registered decision outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_op      <= '0;
            cur_src     <= '0;
            cur_dst     <= '0;
            cur_payload <= '0;
            rsp_valid   <= 1'b0;
            rsp_allowed <= 1'b0;
            rsp_payload <= '0;
            rsp_action  <= '0;
            rsp_code    <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    cur_op      <= fifo_op[rd_ptr];
                    cur_src     <= fifo_src[rd_ptr];
                    cur_dst     <= fifo_dst[rd_ptr];
                    cur_payload <= fifo_payload[rd_ptr];
                    state       <= EVAL;
                end
                EVAL: begin
                    rsp_valid   <= 1'b1;
                    rsp_allowed <= dec_allowed;
                    rsp_payload <= dec_payload;
                    rsp_action  <= dec_action;
                    rsp_code    <= dec_code;
                    state       <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rate window: cycle counter and saturating op count, reset at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            op_cnt  <= '0;
        end else begin
            if (win_wrap) begin
                win_cnt <= '0;
                op_cnt  <= eval_ok ? OPC_W'(1) : '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (eval_ok && (op_cnt != OPC_W'(RATE_MAX)))
                    op_cnt <= op_cnt + 1'b1;
            end
        end
    end

    // Saturating decision statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_block <= '0;
            stat_viol  <= '0;
        end else if (state == EVAL) begin
            if (!dec_allowed && (stat_block != '1))
                stat_block <= stat_block + 1'b1;
            if ((dec_code != 32'd0) && (stat_viol != '1))
                stat_viol <= stat_viol + 1'b1;
        end
    end
endmodule

// File: tb/tb_xrog_policy_engine_pipe.sv
// Directed bench for xrog_policy_engine_pipe (RATE_MAX=2, RATE_WINDOW=64).
`timescale 1ns/1ps
module tb_xrog_policy_engine_pipe;
    localparam int PW = 1024;
    localparam logic [31:0] DAT1 = 32'h4441_5431;
    localparam logic [31:0] RAT1 = 32'h5241_5431;
    localparam logic [31:0] LAT1 = 32'h4C41_5431;

    logic          clk = 0;
    logic          rst = 1;
    logic [127:0]  pol_data = '0;
    logic          pol_load = 0;
    logic          req_valid = 0;
    logic          req_ready;
    logic [7:0]    req_op = '0;
    logic [31:0]   req_src = '0;
    logic [31:0]   req_dst = '0;
    logic [PW-1:0] req_payload = '0;
    logic          rsp_valid;
    logic          rsp_ready = 0;
    logic          rsp_allowed;
    logic [PW-1:0] rsp_payload;
    logic [7:0]    rsp_action;
    logic [31:0]   rsp_code;
    logic [15:0]   stat_block, stat_viol;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    xrog_policy_engine_pipe #(
        .PAYLOAD_W(PW), .DOMAIN_W(32), .POLICY_W(128), .FIFO_DEPTH(4),
        .RISK_THRESH(3), .LAT_THRESH(100), .RATE_WINDOW(64), .RATE_MAX(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .pol_data(pol_data), .pol_load(pol_load),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src(req_src), .req_dst(req_dst), .req_payload(req_payload),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allowed(rsp_allowed),
        .rsp_payload(rsp_payload), .rsp_action(rsp_action), .rsp_code(rsp_code),
        .stat_block(stat_block), .stat_viol(stat_viol), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        pol_load = 0;
        req_valid = 0;
        rsp_ready = 0;
        #12;
        rst = 0;
        step();
    endtask

    task automatic load_pol(input logic [127:0] p);
        pol_data = p;
        pol_load = 1;
        step();
        pol_load = 0;
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] src, input logic [31:0] dst,
                        input logic [63:0] tag);
        int n = 0;
        req_op = op;
        req_src = src;
        req_dst = dst;
        req_payload = '0;
        req_payload[63:0] = tag;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        check_val("push_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1;
        step();
        req_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        check_val("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    logic [127:0] p;
    logic         stable;
    logic [7:0]   h_action;
    logic [31:0]  h_code;
    logic         h_allowed;
    logic [PW-1:0] h_payload;

    initial begin
        // Reset state (sampled while rst is held)
        #3;
        check_val("rst_req_ready", {63'd0, req_ready}, 0);
        check_val("rst_rsp_valid", {63'd0, rsp_valid}, 0);
        check_val("rst_busy", {63'd0, busy}, 0);
        check_val("rst_stat_block", {48'd0, stat_block}, 0);
        rst = 0;
        #1;
        check_val("pre_edge_ready", {63'd0, req_ready}, 0);
        step();
        check_val("ready_after_rst", {63'd0, req_ready}, 1);

        // Unarmed: requests queue, nothing is decided, FIFO fills
        for (int i = 0; i < 4; i++) push(8'd0, 32'h0001_0005, 32'h0001_0005, 64'(i + 1));
        check_val("full_ready", {63'd0, req_ready}, 0);
        check_val("queued_busy", {63'd0, busy}, 1);
        repeat (3) step();
        check_val("unarmed_no_rsp", {63'd0, rsp_valid}, 0);
        load_pol('0);
        for (int i = 0; i < 4; i++) begin
            wait_rsp();
            check_val($sformatf("drain_order%0d", i), rsp_payload[63:0], 64'(i + 1));
            check_val($sformatf("drain_allowed%0d", i), {63'd0, rsp_allowed}, (i < 2) ? 64'd1 : 64'd0);
            check_val($sformatf("drain_action%0d", i), {56'd0, rsp_action}, (i < 2) ? 64'd0 : 64'd3);
            ack_rsp();
        end
        check_val("drain_stat_block", {48'd0, stat_block}, 2);
        check_val("drain_idle", {63'd0, busy}, 0);

        // Residency block
        do_reset();
        p = '0; p[56] = 1'b1;
        load_pol(p);
        push(8'd0, 32'h0001_0005, 32'h0002_0005, 64'h11);
        wait_rsp();
        check_val("res_allowed", {63'd0, rsp_allowed}, 0);
        check_val("res_action", {56'd0, rsp_action}, 1);
        check_val("res_code", {32'd0, rsp_code}, {32'd0, DAT1});
        check_val("res_stat_block", {48'd0, stat_block}, 1);
        check_val("res_stat_viol", {48'd0, stat_viol}, 1);
        ack_rsp();

        // Audit flag on op 4 with high risk
        p = '0; p[31:24] = 8'd5;
        load_pol(p);
        push(8'd4, 32'h0001_0005, 32'h0001_0005, 64'h1234);
        wait_rsp();
        check_val("aud_allowed", {63'd0, rsp_allowed}, 1);
        check_val("aud_action", {56'd0, rsp_action}, 2);
        check_val("aud_msb", {63'd0, rsp_payload[PW-1]}, 1);
        check_val("aud_low", rsp_payload[63:0], 64'h1234);
        check_val("aud_code", {32'd0, rsp_code}, 0);
        check_val("aud_stat_block", {48'd0, stat_block}, 1);
        ack_rsp();

        // Latency flag on a zone crossing
        p = '0; p[95:64] = 32'd50;
        load_pol(p);
        push(8'd0, 32'h0001_0001, 32'h0001_0002, 64'h22);
        wait_rsp();
        check_val("lat_allowed", {63'd0, rsp_allowed}, 1);
        check_val("lat_action", {56'd0, rsp_action}, 0);
        check_val("lat_code", {32'd0, rsp_code}, {32'd0, LAT1});
        check_val("lat_stat_viol", {48'd0, stat_viol}, 2);
        ack_rsp();

        // Rate limit within one window, then release after the wrap
        do_reset();
        load_pol('0);
        for (int i = 0; i < 3; i++) push(8'd0, 32'h0003_0003, 32'h0003_0003, 64'(16 + i));
        for (int i = 0; i < 3; i++) begin
            wait_rsp();
            check_val($sformatf("rate_allowed%0d", i), {63'd0, rsp_allowed}, (i < 2) ? 64'd1 : 64'd0);
            if (i == 2) begin
                check_val("rate_action", {56'd0, rsp_action}, 3);
                check_val("rate_code", {32'd0, rsp_code}, {32'd0, RAT1});
            end
            ack_rsp();
        end
        check_val("rate_same_window", {63'd0, (cyc < 60)}, 1);
        while (cyc < 70) step();
        push(8'd0, 32'h0003_0003, 32'h0003_0003, 64'h33);
        wait_rsp();
        check_val("rate_after_wrap", {63'd0, rsp_allowed}, 1);
        check_val("rate_after_wrap_code", {32'd0, rsp_code}, 0);
        ack_rsp();

        // Stall with policy change, then reset mid-EVAL
        do_reset();
        p = '0; p[31:24] = 8'd5;
        load_pol(p);
        push(8'd4, 32'h0001_0005, 32'h0002_0005, 64'h44);
        wait_rsp();
        h_action = rsp_action; h_code = rsp_code; h_allowed = rsp_allowed; h_payload = rsp_payload;
        check_val("stall_first_action", {56'd0, h_action}, 2);
        stable = 1;
        p = '0; p[56] = 1'b1;
        pol_data = p;
        pol_load = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            pol_load = 0;
            if (!rsp_valid || rsp_action != h_action || rsp_code != h_code ||
                rsp_allowed != h_allowed || rsp_payload != h_payload) stable = 0;
        end
        check_val("stall_stable", {63'd0, stable}, 1);
        ack_rsp();
        push(8'd0, 32'h0001_0005, 32'h0002_0005, 64'h55);
        wait_rsp();
        check_val("newpol_action", {56'd0, rsp_action}, 1);
        check_val("newpol_code", {32'd0, rsp_code}, {32'd0, DAT1});
        ack_rsp();
        push(8'd0, 32'h0001_0005, 32'h0002_0005, 64'h66);
        step();
        check_val("pre_rst_busy", {63'd0, busy}, 1);
        rst = 1;
        #1;
        check_val("mid_rst_busy", {63'd0, busy}, 0);
        check_val("mid_rst_valid", {63'd0, rsp_valid}, 0);
        check_val("mid_rst_ready", {63'd0, req_ready}, 0);
        check_val("mid_rst_code", {32'd0, rsp_code}, 0);
        check_val("mid_rst_stat", {48'd0, stat_block}, 0);
        #10;
        rst = 0;
        repeat (4) step();
        check_val("post_rst_no_rsp", {63'd0, rsp_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
